rd_timeout_checker: RTL and testbench
=====================================

Name: rd_timeout_checker

Overview:
Downstream of the per-slot read-phase counters in the AXI monitor. Each cycle it compares every busy slot's four read-phase counters against programmable budgets and marks per-slot timeouts. It records the first offending transaction, raises an interrupt and a reset request toward the guarded subordinate, and keeps a saturating count of timed-out transactions.

Parameters:
NumSlots, 4, number of tracked outstanding read slots (>=1)
CntWidth, 8, width of each phase counter and each budget
IdWidth, 4, AXI read ID width
StatWidth, 8, width of timeout statistics counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
check_en_i  input  1  1 enables detection of new violations
slot_busy_i  input  NumSlots  slot holds an outstanding read
slot_phase_i  input  2*NumSlots  per slot: 0 idle, 1 AR phase, 2 R phase, 3 reserved
slot_id_i  input  IdWidth*NumSlots  AXI ID per slot
cnt_ar_i  input  CntWidth*NumSlots  ARVALID->ARREADY count
cnt_arfirst_i  input  CntWidth*NumSlots  ARVALID->first RVALID count
cnt_rfirst_i  input  CntWidth*NumSlots  first RVALID->RREADY count
cnt_rlast_i  input  CntWidth*NumSlots  first R->RLAST count
budget_ar_i, budget_arfirst_i, budget_rfirst_i, budget_rlast_i  input  CntWidth each  limits; 0 disables that check
reset_ack_i  input  1  subordinate reset completed
irq_clr_i  input  1  software clears interrupt
slot_timeout_o  output  NumSlots  sticky per-slot timeout flag
timeout_valid_o  output  1  first-error record valid
timeout_slot_o  output  $clog2(NumSlots) (min 1)  slot of first error
timeout_id_o  output  IdWidth  AXI ID of first error
timeout_cause_o  output  4  violating checks {rlast,rfirst,arfirst,ar}
timeout_cnt_o  output  StatWidth  timed-out transactions, saturating
irq_o  output  1  interrupt
reset_req_o  output  1  reset request to subordinate

Behaviour:
- Reset: all outputs 0, FSM IDLE, sticky flags 0.
- Violation per slot (combinational): check_en_i & slot_busy_i & (phase==1 & ((b_ar!=0 & cnt_ar>=b_ar) | (b_arfirst!=0 & cnt_arfirst>=b_arfirst)) | phase==2 & ((b_rfirst!=0 & cnt_rfirst>=b_rfirst) | (b_rlast!=0 & cnt_rlast>=b_rlast))). Compare unsigned, full CntWidth. Phase 0/3 never violates.
- Sticky: slot_timeout_o[i] set the cycle after a violation; cleared the cycle after slot_busy_i[i]=0. busy=0 wins over simultaneous violation. Stays set while busy even if check_en_i drops.
- New timeout = violation & !slot_timeout_o[i]. timeout_cnt_o += popcount(new timeouts) each cycle, saturating at 2^StatWidth-1; one count per slot per transaction.
- FSM IDLE/REQ/HOLD:
  IDLE: any new timeout -> latch record of lowest-index new slot (slot, id, cause = 4-bit mask of its failing checks at that cycle), timeout_valid_o=1, -> REQ. Latency 1 cycle.
  REQ: reset_req_o=1, irq_o=1; reset_ack_i -> HOLD. irq_clr_i ignored.
  HOLD: reset_req_o=0, irq_o=1; irq_clr_i -> IDLE, timeout_valid_o=0 next cycle.
  reset_ack_i and irq_clr_i in the same REQ cycle: go HOLD only.
- First error wins: record never overwritten outside IDLE; later timeouts only set sticky flags and count.
- Record persists in IDLE until replaced by the next first error.
- reset_ack_i outside REQ is ignored.
- Asynchronous reset mid-REQ/HOLD: immediate return to reset values, with no handshake.

Test Plan:
- budget_ar=5, slot0 busy phase1 cnt_ar 0..5, ID 3 -> at cnt_ar=5, next cycle slot_timeout_o=0001, timeout_slot=0, id=3, cause=0001, irq_o=reset_req_o=1, cnt=1.
- Same as above; reset_ack_i pulse -> reset_req_o=0, irq_o=1; irq_clr_i -> irq_o=0, timeout_valid_o=0.
- Slots 1 and 2 violate in the same cycle (rfirst on slot 1, rlast+rfirst on slot 2) -> record slot 1 cause 0100, slot_timeout_o=0110, cnt=2.
- All budgets 0 with counters saturated, or check_en_i=0 -> no flags, irq_o=0, cnt=0.
- Slot busy drops in the same cycle it violates -> no flag, cnt unchanged. StatWidth=2 with 5 timeouts -> cnt_o=3.
- Assert rst_ni low during REQ -> all outputs 0 immediately, FSM IDLE after release.

Source files
------------

// File: rtl/rd_timeout_checker_if.sv
// Signal bundle between the per-slot read-phase counters and the timeout checker.
// The slave side belongs to the checker; the master side drives counters/budgets and observes results.
interface rd_timeout_checker_if #(
    parameter int NumSlots  = 4,
    parameter int CntWidth  = 8,
    parameter int IdWidth   = 4,
    parameter int StatWidth = 8
);
    localparam int SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    logic                          check_en_i;
    logic [NumSlots-1:0]           slot_busy_i;
    logic [2*NumSlots-1:0]         slot_phase_i;
    logic [IdWidth*NumSlots-1:0]   slot_id_i;
    logic [CntWidth*NumSlots-1:0]  cnt_ar_i;
    logic [CntWidth*NumSlots-1:0]  cnt_arfirst_i;
    logic [CntWidth*NumSlots-1:0]  cnt_rfirst_i;
    logic [CntWidth*NumSlots-1:0]  cnt_rlast_i;
    logic [CntWidth-1:0]           budget_ar_i;
    logic [CntWidth-1:0]           budget_arfirst_i;
    logic [CntWidth-1:0]           budget_rfirst_i;
    logic [CntWidth-1:0]           budget_rlast_i;
    logic                          reset_ack_i;
    logic                          irq_clr_i;

    logic [NumSlots-1:0]           slot_timeout_o;
    logic                          timeout_valid_o;
    logic [SlotW-1:0]              timeout_slot_o;
    logic [IdWidth-1:0]            timeout_id_o;
    logic [3:0]                    timeout_cause_o;
    logic [StatWidth-1:0]          timeout_cnt_o;
    logic                          irq_o;
    logic                          reset_req_o;

    modport slave (
        input  check_en_i, slot_busy_i, slot_phase_i, slot_id_i,
               cnt_ar_i, cnt_arfirst_i, cnt_rfirst_i, cnt_rlast_i,
               budget_ar_i, budget_arfirst_i, budget_rfirst_i, budget_rlast_i,
               reset_ack_i, irq_clr_i,
        output slot_timeout_o, timeout_valid_o, timeout_slot_o, timeout_id_o,
               timeout_cause_o, timeout_cnt_o, irq_o, reset_req_o
    );

    modport master (
        output check_en_i, slot_busy_i, slot_phase_i, slot_id_i,
               cnt_ar_i, cnt_arfirst_i, cnt_rfirst_i, cnt_rlast_i,
               budget_ar_i, budget_arfirst_i, budget_rfirst_i, budget_rlast_i,
               reset_ack_i, irq_clr_i,
        input  slot_timeout_o, timeout_valid_o, timeout_slot_o, timeout_id_o,
               timeout_cause_o, timeout_cnt_o, irq_o, reset_req_o
    );
endinterface

// File: rtl/rd_timeout_checker.sv
// Per-slot AXI read-phase budget checker: sticky timeout flags, first-error record,
// saturating timeout count and an irq / subordinate-reset handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no open error; next new timeout latches the record
// REQ     | reset_req_o and irq_o high, waiting for reset_ack_i
// HOLD    | subordinate reset done, irq_o held until irq_clr_i
module rd_timeout_checker #(
    parameter int NumSlots  = 4,
    parameter int CntWidth  = 8,
    parameter int IdWidth   = 4,
    parameter int StatWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rd_timeout_checker_if.slave  bus_if
);
    localparam int SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int PopW  = $clog2(NumSlots + 1);
    localparam int SumW  = ((StatWidth > PopW) ? StatWidth : PopW) + 1;
    localparam logic [SumW-1:0] SatVal = {{(SumW-StatWidth){1'b0}}, {StatWidth{1'b1}}};

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_e;

    state_e                     r_state, w_state_nxt;
    logic [NumSlots-1:0]        r_sticky;
    logic [NumSlots-1:0]        w_viol;
    logic [NumSlots-1:0]        w_new;
    logic [NumSlots-1:0][3:0]   w_cause;
    logic                       r_valid;
    logic [SlotW-1:0]           r_slot;
    logic [IdWidth-1:0]         r_id;
    logic [3:0]                 r_cause;
    logic [StatWidth-1:0]       r_cnt;
    logic [SlotW-1:0]           w_first_slot;
    logic [IdWidth-1:0]         w_first_id;
    logic [3:0]                 w_first_cause;
    logic [PopW-1:0]            w_pop;
    logic [SumW-1:0]            w_sum;
    logic                       w_irq;
    logic                       w_reset_req;

    // Cause bits are {rlast, rfirst, arfirst, ar}; a zero budget disables its check.
    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        logic [1:0] w_phase;
        logic       w_en;
        assign w_phase = bus_if.slot_phase_i[2*g +: 2];
        assign w_en    = bus_if.check_en_i & bus_if.slot_busy_i[g];

        assign w_cause[g][0] = w_en && (w_phase == 2'd1) && (bus_if.budget_ar_i != '0) &&
                               (bus_if.cnt_ar_i[g*CntWidth +: CntWidth] >= bus_if.budget_ar_i);
        assign w_cause[g][1] = w_en && (w_phase == 2'd1) && (bus_if.budget_arfirst_i != '0) &&
                               (bus_if.cnt_arfirst_i[g*CntWidth +: CntWidth] >= bus_if.budget_arfirst_i);
        assign w_cause[g][2] = w_en && (w_phase == 2'd2) && (bus_if.budget_rfirst_i != '0) &&
                               (bus_if.cnt_rfirst_i[g*CntWidth +: CntWidth] >= bus_if.budget_rfirst_i);
        assign w_cause[g][3] = w_en && (w_phase == 2'd2) && (bus_if.budget_rlast_i != '0) &&
                               (bus_if.cnt_rlast_i[g*CntWidth +: CntWidth] >= bus_if.budget_rlast_i);
        assign w_viol[g]     = |w_cause[g];
    end

    assign w_new = w_viol & ~r_sticky;

    always_comb begin
        w_first_slot  = '0;
        w_first_id    = '0;
        w_first_cause = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (w_new[i]) begin
                w_first_slot  = SlotW'(i);
                w_first_id    = bus_if.slot_id_i[i*IdWidth +: IdWidth];
                w_first_cause = w_cause[i];
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_pop = w_pop + PopW'(w_new[i]);
        end
    end

    assign w_sum = SumW'(r_cnt) + SumW'(w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky <= '0;
            r_cnt    <= '0;
        end else begin
            r_sticky <= (r_sticky | w_viol) & bus_if.slot_busy_i;
            r_cnt    <= (w_sum > SatVal) ? {StatWidth{1'b1}} : w_sum[StatWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_new)              w_state_nxt = ST_REQ;
            ST_REQ:  if (bus_if.reset_ack_i)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (bus_if.irq_clr_i)    w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_irq       = 1'b0;
        w_reset_req = 1'b0;
        case (r_state)
            ST_REQ:  begin w_irq = 1'b1; w_reset_req = 1'b1; end
            ST_HOLD: w_irq = 1'b1;
            default: ;
        endcase
    end

    // The record only loads in IDLE, so the first error of an episode is never overwritten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
            r_id    <= '0;
            r_cause <= '0;
        end else if (r_state == ST_IDLE && |w_new) begin
            r_valid <= 1'b1;
            r_slot  <= w_first_slot;
            r_id    <= w_first_id;
            r_cause <= w_first_cause;
        end else if (r_state == ST_HOLD && bus_if.irq_clr_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bus_if.slot_timeout_o  = r_sticky;
    assign bus_if.timeout_valid_o = r_valid;
    assign bus_if.timeout_slot_o  = r_slot;
    assign bus_if.timeout_id_o    = r_id;
    assign bus_if.timeout_cause_o = r_cause;
    assign bus_if.timeout_cnt_o   = r_cnt;
    assign bus_if.irq_o           = w_irq;
    assign bus_if.reset_req_o     = w_reset_req;
endmodule

// File: tb/tb_rd_timeout_checker.sv
// Scoreboard bench for rd_timeout_checker: a behavioural model queues the expected outputs
// per cycle and a negedge monitor compares them; a StatWidth=2 copy checks count saturation.
module tb_rd_timeout_checker;
    localparam int NS = 4;
    localparam int CW = 8;
    localparam int IW = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    rd_timeout_checker_if #(.NumSlots(NS), .CntWidth(CW), .IdWidth(IW), .StatWidth(8)) bus ();
    rd_timeout_checker_if #(.NumSlots(NS), .CntWidth(CW), .IdWidth(IW), .StatWidth(2)) bus2 ();

    rd_timeout_checker #(.NumSlots(NS), .CntWidth(CW), .IdWidth(IW), .StatWidth(8)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus_if(bus)
    );
    rd_timeout_checker #(.NumSlots(NS), .CntWidth(CW), .IdWidth(IW), .StatWidth(2)) u_dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus_if(bus2)
    );

    assign bus2.check_en_i       = bus.check_en_i;
    assign bus2.slot_busy_i      = bus.slot_busy_i;
    assign bus2.slot_phase_i     = bus.slot_phase_i;
    assign bus2.slot_id_i        = bus.slot_id_i;
    assign bus2.cnt_ar_i         = bus.cnt_ar_i;
    assign bus2.cnt_arfirst_i    = bus.cnt_arfirst_i;
    assign bus2.cnt_rfirst_i     = bus.cnt_rfirst_i;
    assign bus2.cnt_rlast_i      = bus.cnt_rlast_i;
    assign bus2.budget_ar_i      = bus.budget_ar_i;
    assign bus2.budget_arfirst_i = bus.budget_arfirst_i;
    assign bus2.budget_rfirst_i  = bus.budget_rfirst_i;
    assign bus2.budget_rlast_i   = bus.budget_rlast_i;
    assign bus2.reset_ack_i      = bus.reset_ack_i;
    assign bus2.irq_clr_i        = bus.irq_clr_i;

    // stimulus state
    bit       en;
    bit [3:0] busy;
    int       phase [NS];
    int       sid   [NS];
    int       car   [NS];
    int       carf  [NS];
    int       crf   [NS];
    int       crl   [NS];
    int       b_ar, b_arf, b_rf, b_rl;
    bit       ack, clr;

    // reference model state
    bit [3:0] m_flags;
    bit       m_valid, m_irq, m_req;
    int       m_slot, m_id, m_cause, m_cnt, m_cnt2;

    typedef struct {
        int flags; int valid; int slot; int id; int cause;
        int cnt; int cnt2; int irq; int req;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.check_en_i       = en;
        bus.slot_busy_i      = busy;
        bus.budget_ar_i      = CW'(b_ar);
        bus.budget_arfirst_i = CW'(b_arf);
        bus.budget_rfirst_i  = CW'(b_rf);
        bus.budget_rlast_i   = CW'(b_rl);
        bus.reset_ack_i      = ack;
        bus.irq_clr_i        = clr;
        for (int i = 0; i < NS; i++) begin
            bus.slot_phase_i[2*i +: 2]   = 2'(phase[i]);
            bus.slot_id_i[IW*i +: IW]    = IW'(sid[i]);
            bus.cnt_ar_i[CW*i +: CW]     = CW'(car[i]);
            bus.cnt_arfirst_i[CW*i +: CW] = CW'(carf[i]);
            bus.cnt_rfirst_i[CW*i +: CW] = CW'(crf[i]);
            bus.cnt_rlast_i[CW*i +: CW]  = CW'(crl[i]);
        end
    endtask

    task automatic model_reset();
        m_flags = '0; m_valid = 0; m_irq = 0; m_req = 0;
        m_slot = 0; m_id = 0; m_cause = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // Next-cycle expectation from this cycle's inputs and the current model state.
    task automatic model_step();
        int       nnew = 0;
        int       first = -1;
        int       fc = 0;
        bit [3:0] vio = '0;
        exp_t     e;
        for (int i = 0; i < NS; i++) begin
            int c = 0;
            if (en && busy[i]) begin
                if (phase[i] == 1) begin
                    if (b_ar  != 0 && car[i]  >= b_ar)  c += 1;
                    if (b_arf != 0 && carf[i] >= b_arf) c += 2;
                end else if (phase[i] == 2) begin
                    if (b_rf != 0 && crf[i] >= b_rf) c += 4;
                    if (b_rl != 0 && crl[i] >= b_rl) c += 8;
                end
            end
            vio[i] = (c != 0);
            if (vio[i] && !m_flags[i]) begin
                nnew++;
                if (first < 0) begin first = i; fc = c; end
            end
        end
        if (!m_irq) begin
            if (first >= 0) begin
                m_valid = 1; m_slot = first; m_id = sid[first]; m_cause = fc;
                m_irq = 1; m_req = 1;
            end
        end else if (m_req) begin
            if (ack) m_req = 0;
        end else if (clr) begin
            m_irq = 0; m_valid = 0;
        end
        m_cnt  = (m_cnt + nnew > 255) ? 255 : m_cnt + nnew;
        m_cnt2 = (m_cnt2 + nnew > 3) ? 3 : m_cnt2 + nnew;
        for (int i = 0; i < NS; i++) m_flags[i] = busy[i] ? (m_flags[i] | vio[i]) : 1'b0;
        e.flags = int'(m_flags); e.valid = int'(m_valid); e.slot = m_slot; e.id = m_id;
        e.cause = m_cause; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.irq = int'(m_irq); e.req = int'(m_req);
        q.push_back(e);
    endtask

    task automatic step();
        drive();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        ack = 0;
        clr = 0;
    endtask

    task automatic idle_inputs();
        en = 1; busy = '0; ack = 0; clr = 0;
        b_ar = 0; b_arf = 0; b_rf = 0; b_rl = 0;
        for (int i = 0; i < NS; i++) begin
            phase[i] = 0; sid[i] = 0; car[i] = 0; carf[i] = 0; crf[i] = 0; crl[i] = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 32'(bus.slot_timeout_o), 0);
        chk({tag, "_valid"}, 32'(bus.timeout_valid_o), 0);
        chk({tag, "_slot"},  32'(bus.timeout_slot_o), 0);
        chk({tag, "_id"},    32'(bus.timeout_id_o), 0);
        chk({tag, "_cause"}, 32'(bus.timeout_cause_o), 0);
        chk({tag, "_cnt"},   32'(bus.timeout_cnt_o), 0);
        chk({tag, "_irq"},   32'(bus.irq_o), 0);
        chk({tag, "_req"},   32'(bus.reset_req_o), 0);
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; compare it to the queued one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("flags", 32'(bus.slot_timeout_o), 32'(e.flags));
                chk("valid", 32'(bus.timeout_valid_o), 32'(e.valid));
                if (e.valid != 0) begin
                    chk("slot",  32'(bus.timeout_slot_o), 32'(e.slot));
                    chk("id",    32'(bus.timeout_id_o), 32'(e.id));
                    chk("cause", 32'(bus.timeout_cause_o), 32'(e.cause));
                end
                chk("cnt",   32'(bus.timeout_cnt_o), 32'(e.cnt));
                chk("cnt_sat2", 32'(bus2.timeout_cnt_o), 32'(e.cnt2));
                chk("irq",   32'(bus.irq_o), 32'(e.irq));
                chk("rreq",  32'(bus.reset_req_o), 32'(e.req));
            end
        end
    end

    initial begin
        idle_inputs();
        drive();
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk_i);
        #1 rst_ni = 1'b1;

        // AR budget 5 on slot 0, then ack and clear the interrupt
        b_ar = 5; busy = 4'b0001; phase[0] = 1; sid[0] = 3;
        for (int k = 0; k <= 5; k++) begin car[0] = k; step(); end
        step();
        ack = 1; step();
        step();
        clr = 1; step();
        busy = '0; step();

        // slots 1 and 2 violate together; ack+clr in one REQ cycle goes to HOLD only
        idle_inputs();
        b_rf = 4; b_rl = 6;
        busy = 4'b0110; phase[1] = 2; phase[2] = 2; sid[1] = 9; sid[2] = 12;
        crf[1] = 4; crl[1] = 0; crf[2] = 5; crl[2] = 7;
        step();
        ack = 1; clr = 1; step();
        clr = 1; step();
        busy = '0; step();

        // disabled budgets with saturated counters, then check_en low
        idle_inputs();
        busy = 4'b1111;
        for (int i = 0; i < NS; i++) begin
            phase[i] = 1 + (i % 2); car[i] = 255; carf[i] = 255; crf[i] = 255; crl[i] = 255;
        end
        step(); step();
        b_ar = 1; b_arf = 1; b_rf = 1; b_rl = 1; en = 0;
        step(); step();

        // all four violate together (count passes 3 on the narrow copy), busy drops while violating
        en = 1;
        step();
        ack = 1; step();
        clr = 1; step();
        busy = 4'b0111; step();
        busy = 4'b0000; step();

        // randomized traffic
        idle_inputs();
        for (int seg = 0; seg < 4; seg++) begin
            b_ar = $urandom_range(12); b_arf = $urandom_range(12);
            b_rf = $urandom_range(12); b_rl = $urandom_range(12);
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < NS; i++) begin
                    if (busy[i]) begin
                        if ($urandom_range(7) == 0) busy[i] = 0;
                        else begin
                            car[i] += $urandom_range(1); carf[i] += $urandom_range(1);
                            crf[i] += $urandom_range(1); crl[i] += $urandom_range(1);
                            if ($urandom_range(9) == 0) phase[i] = $urandom_range(3);
                        end
                    end else if ($urandom_range(2) == 0) begin
                        busy[i] = 1; phase[i] = $urandom_range(1, 2); sid[i] = $urandom_range(15);
                        car[i] = $urandom_range(15); carf[i] = $urandom_range(15);
                        crf[i] = $urandom_range(15); crl[i] = $urandom_range(15);
                    end
                end
                en  = ($urandom_range(9) != 0);
                ack = ($urandom_range(3) == 0);
                clr = ($urandom_range(4) == 0);
                step();
            end
        end

        // async reset while in REQ
        idle_inputs();
        busy = 4'b0001; step();
        b_arf = 2; phase[0] = 1; carf[0] = 3; sid[0] = 5; step();
        #2 rst_ni = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        idle_inputs();
        drive();
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        step();
        step();

        @(negedge clk_i);
        #1;
        chk("queue_drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
